// File: rtl/pmem_pkg.sv
// Shared types and constants for the cache-line to memory-burst adapter.
package pmem_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int CNT_W    = $clog2(BEATS);

  localparam logic [31:0] OFFSET_MASK = (32'd1 << OFFSET_W) - 32'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_t;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

  // Clear the byte-offset bits so every burst starts on a line boundary.
  function automatic logic [31:0] align_address(input logic [31:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

endpackage

// File: rtl/pmem_burst_adapter.sv
// Turns one full-line cache read/write into a 4-beat 64-bit memory burst and
// answers the cache with a single-cycle line_resp once the line is complete.
module pmem_burst_adapter
  import pmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] line_address,
  input  logic        line_read,
  input  logic        line_write,
  input  line_t       line_wdata,
  output line_t       line_rdata,
  output logic        line_resp,
  output logic [31:0] burst_address,
  output logic        burst_read,
  output logic        burst_write,
  output beat_t       burst_wdata,
  input  beat_t       burst_rdata,
  input  logic        burst_resp
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adapter_state_t   state_r;
  adapter_state_t   state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [31:0]      addr_r;
  line_t            wline_r;
  line_t            rdata_r;
  logic             line_resp_r;
  logic             burst_read_r;
  logic             burst_write_r;
  logic             accept_s;
  beat_t            burst_wdata_s;

  assign accept_s = (state_r == IDLE) && (line_write || line_read);

  // Next-state and beat-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (line_write) begin
          state_s = WRITE;
        end else if (line_read) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ, WRITE: begin
        if (burst_resp) begin
          // Counter wraps to zero naturally on the last beat.
          cnt_s = cnt_r + 2'd1;
          if (cnt_r == LAST_BEAT) begin
            state_s = DONE;
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // State, latched request, read buffer and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      cnt_r         <= 2'd0;
      addr_r        <= 32'd0;
      wline_r       <= '0;
      rdata_r       <= '0;
      line_resp_r   <= 1'b0;
      burst_read_r  <= 1'b0;
      burst_write_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      line_resp_r   <= (state_s == DONE);
      burst_read_r  <= (state_s == READ);
      burst_write_r <= (state_s == WRITE);
      if (accept_s) begin
        addr_r <= align_address(line_address);
      end
      if ((state_r == IDLE) && line_write) begin
        wline_r <= line_wdata;
      end
      if ((state_r == READ) && burst_resp) begin
        rdata_r[cnt_r*BEAT_W +: BEAT_W] <= burst_rdata;
      end
    end
  end

  // Current write beat follows the counter directly.
  always_comb begin
    burst_wdata_s = '0;
    if (state_r == WRITE) begin
      burst_wdata_s = wline_r[cnt_r*BEAT_W +: BEAT_W];
    end else begin
      burst_wdata_s = '0;
    end
  end

  assign line_rdata    = rdata_r;
  assign line_resp     = line_resp_r;
  assign burst_address = addr_r;
  assign burst_read    = burst_read_r;
  assign burst_write   = burst_write_r;
  assign burst_wdata   = burst_wdata_s;

endmodule

// File: doc/pmem_burst_adapter.md
Name: pmem_burst_adapter

Overview:
- Physical-memory-side responder for the set-associative cache's 256-bit line interface (pmem_address / pmem_rdata / pmem_wdata plus read/write/resp handshake).
- Accepts one full-line read or write from the cache.
- Converts it into a 4-beat, 64-bit burst to main memory.
- Returns a single-cycle resp to the cache once the line is assembled or fully written.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory burst beat width in bits.
- BEATS, LINE_W/BEAT_W (4), beats per line; derived, not overridden.
- OFFSET_W, $clog2(LINE_W/8) (5), line byte-offset bits cleared on the memory address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- line_address  in  32  line address from the cache (pmem_address).
- line_read  in  1  cache line-read request; held until line_resp.
- line_write  in  1  cache line-write request; held until line_resp.
- line_wdata  in  LINE_W  line to write back (pmem_wdata).
- line_rdata  out  LINE_W  assembled line for the cache (pmem_rdata).
- line_resp  out  1  one-cycle completion pulse to the cache.
- burst_address  out  32  aligned burst address to memory.
- burst_read  out  1  memory read request.
- burst_write  out  1  memory write request.
- burst_wdata  out  BEAT_W  current write beat.
- burst_rdata  in  BEAT_W  incoming read beat.
- burst_resp  in  1  memory beat strobe; one beat per high cycle.

Behaviour:
- States: IDLE, READ, WRITE, DONE. State, beat counter (2 bits), latched address, latched line and rdata buffer are all registered.
- Reset (rst low, asynchronous): state IDLE, counter 0, line_rdata 0, line_resp 0, burst_read 0, burst_write 0, burst_address 0, burst_wdata 0. Reset mid-burst abandons the transfer; the memory model is reset in the same cycle.
- IDLE:
  - line_write high: latch line_wdata and {line_address[31:OFFSET_W], 0}, go to WRITE.
  - Otherwise line_read high: latch the address, go to READ.
  - Write takes priority when both are high. The cache never drives both; the bench flags it.
  - Requests are sampled only in IDLE.
- READ:
  - burst_read = 1; burst_address = latched address.
  - Each cycle with burst_resp = 1 writes burst_rdata into beat slot [counter], bits [counter*64 +: 64] (beat 0 = LSBs), then increments the counter.
  - Cycles with burst_resp = 0 are stalls; any number of gaps is allowed.
  - On the 4th beat (counter = 3 with resp): go to DONE, counter wraps to 0.
- WRITE:
  - burst_write = 1; burst_wdata = latched line beat [counter], driven combinationally from the counter.
  - Each burst_resp = 1 advances the counter.
  - 4th beat: go to DONE.
- DONE:
  - line_resp = 1 for exactly this one cycle.
  - burst_read = burst_write = 0.
  - Unconditionally return to IDLE.
- line_rdata holds the assembled line from the first DONE cycle until the next READ's first beat overwrites slot 0. Partially filled slots are never observed with line_resp high.
- Latency, zero-wait memory: request at cycle T (IDLE), beats at T+1..T+4, line_resp at T+5. The cache deasserts its request at T+6.
- burst_resp while in IDLE or DONE is ignored; counter and buffer are unchanged.
- Request changes during READ/WRITE are ignored; the latched address and line are used.

Decomposition:
- Shared package pmem_pkg holds:
  - typedef enum {IDLE, READ, WRITE, DONE} adapter_state_t;
  - constants LINE_W, BEAT_W, BEATS, OFFSET_W;
  - typedefs line_t = logic [LINE_W-1:0] and beat_t = logic [BEAT_W-1:0].
- No sub-module; FSM, counter and shift/slot buffer stay in one file (~150 lines).
- The bench memory model pmem_burst_model lives in the test tree only.

Test Plan:
- Read, zero-wait: line_read, line_address=0x1234_5678; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> burst_address=0x1234_5660; line_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; line_resp single pulse 5 cycles after the request.
- Write: line_write, line_wdata = {0xD..,0xC..,0xB..,0xA..}, address 0x0000_00A4 -> burst_address=0x0000_00A0; burst_wdata A, B, C, D on successive resp cycles; burst_write drops after the 4th; one line_resp.
- Stalled read: burst_resp pattern 1,0,0,1,0,1,1 -> exactly 4 beats captured in order; line_resp only after the 7th cycle; no early pulse.
- Both line_read and line_write high in IDLE -> WRITE taken, burst_read never asserted.
- Reset mid-read after 2 beats (rst low 1 cycle) -> all outputs 0 immediately (asynchronous); the next read returns a full new line with no stale beats; no line_resp for the aborted transfer.
- Back-to-back write-then-read (writeback then fill, cache-style) -> two separate line_resp pulses; the read line is correct; the counter starts at 0 for each.
